// File: rtl/approx_err_pkg.sv
// Shared types and default widths for the approximate-adder error monitor.
package approx_err_pkg;

  localparam int unsigned N         = 16;
  localparam int unsigned FRAC      = 8;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned ED_W      = N;
  localparam int unsigned Q_W       = N + FRAC;
  localparam int unsigned SUM_RED_W = N + FRAC + CNT_W;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDiv,
    StDone
  } state_e;

endpackage

// File: rtl/seq_restoring_div.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, DW iterations per load.
// q_valid marks the final iteration; quotient carries the finished result in that same cycle.
module seq_restoring_div #(
  parameter int unsigned DW = 24,
  parameter int unsigned VW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          q_valid,
  output logic [DW-1:0] quotient
);

  localparam int unsigned CntW = $clog2(DW + 1);

  logic [CntW-1:0] cnt_q;
  logic [DW-1:0]   dvd_q, dvd_d;
  logic [VW-1:0]   rem_q, rem_d, dvs_q;
  logic [VW:0]     rem_sh, trial;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh = {rem_q, dvd_q[DW-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    rem_d  = rem_sh[VW-1:0];
    dvd_d  = {dvd_q[DW-2:0], 1'b0};
    if (rem_sh >= {1'b0, dvs_q}) begin
      rem_d = trial[VW-1:0];
      dvd_d = {dvd_q[DW-2:0], 1'b1};
    end
  end

  // Iteration state; the dividend register fills with quotient bits from the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      dvd_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      cnt_q <= CntW'(DW);
      dvd_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (busy) begin
      cnt_q <= cnt_q - CntW'(1);
      dvd_q <= dvd_d;
      rem_q <= rem_d;
    end
  end

  assign busy     = (cnt_q != '0);
  assign q_valid  = (cnt_q == CntW'(1));
  assign quotient = dvd_d;

endmodule

// File: rtl/approx_error_monitor.sv
// Accumulates raw ER/MED/MRED/NMED terms over a stream of (approx, exact) sum pairs.
// The host divides the accumulators by the sample counts afterwards.
module approx_error_monitor #(
  parameter int unsigned N     = approx_err_pkg::N,
  parameter int unsigned CNT_W = approx_err_pkg::CNT_W,
  parameter int unsigned FRAC  = approx_err_pkg::FRAC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_samples,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            approx_s,
  input  logic [N-1:0]            exact_s,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        err_count,
  output logic [N+CNT_W-1:0]      sum_ed,
  output logic [N-1:0]            max_ed,
  output logic [N+FRAC+CNT_W-1:0] sum_red,
  output logic [CNT_W-1:0]        nz_count
);

  import approx_err_pkg::*;

  localparam int unsigned QW     = N + FRAC;
  localparam int unsigned SumEdW = N + CNT_W;
  localparam int unsigned SumRdW = N + FRAC + CNT_W;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] remaining_q;
  logic [N-1:0]    ed;
  logic            accept, start_ok, need_div;
  logic            div_busy, div_q_valid;
  logic [QW-1:0]   div_quotient;

  assign ed       = (approx_s >= exact_s) ? (approx_s - exact_s) : (exact_s - approx_s);
  assign accept   = in_valid && in_ready;
  assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
  // Zero exact sums are excluded from MRED; zero ED gives a zero quotient without dividing.
  assign need_div = (exact_s != '0) && (ed != '0);

  seq_restoring_div #(
    .DW (QW),
    .VW (N)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && need_div),
    .dividend ({ed, {FRAC{1'b0}}}),
    .divisor  (exact_s),
    .busy     (div_busy),
    .q_valid  (div_q_valid),
    .quotient (div_quotient)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = (num_samples == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (accept) begin
          if (need_div) begin
            state_d = StDiv;
          end else if (remaining_q == CNT_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDiv: begin
        if (div_q_valid) begin
          state_d = (remaining_q == '0) ? StDone : StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake and status outputs follow the state directly.
  always_comb begin
    in_ready = (state_q == StRun);
    busy     = (state_q == StRun) || (state_q == StDiv);
    done     = (state_q == StDone);
  end

  // Accumulators: cleared on start, updated the cycle after acceptance or quotient arrival.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_q <= '0;
      err_count   <= '0;
      sum_ed      <= '0;
      max_ed      <= '0;
      sum_red     <= '0;
      nz_count    <= '0;
    end else if (start_ok) begin
      remaining_q <= num_samples;
      err_count   <= '0;
      sum_ed      <= '0;
      max_ed      <= '0;
      sum_red     <= '0;
      nz_count    <= '0;
    end else if (accept) begin
      remaining_q <= remaining_q - CNT_W'(1);
      if (ed != '0) begin
        err_count <= err_count + CNT_W'(1);
      end
      if (exact_s != '0) begin
        nz_count <= nz_count + CNT_W'(1);
      end
      sum_ed <= sum_ed + SumEdW'(ed);
      if (ed > max_ed) begin
        max_ed <= ed;
      end
    end else if ((state_q == StDiv) && div_q_valid) begin
      sum_red <= sum_red + SumRdW'(div_quotient);
    end
  end

  // Divider busy is implied by StDiv; kept only as a handy probe.
  logic unused_div_busy;
  assign unused_div_busy = div_busy;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Directed self-checking bench for approx_error_monitor.
module tb_approx_error_monitor;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] num_samples;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] approx_s;
  logic [15:0] exact_s;
  logic        busy;
  logic        done;
  logic [31:0] err_count;
  logic [47:0] sum_ed;
  logic [15:0] max_ed;
  logic [55:0] sum_red;
  logic [31:0] nz_count;

  int checks;
  int failures;
  int low_cnt;

  approx_error_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .approx_s    (approx_s),
    .exact_s     (exact_s),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .sum_ed      (sum_ed),
    .max_ed      (max_ed),
    .sum_red     (sum_red),
    .nz_count    (nz_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_results(input string tag, input logic [63:0] e_err, input logic [63:0] e_sed,
                             input logic [63:0] e_max, input logic [63:0] e_red,
                             input logic [63:0] e_nz);
    chk({tag, "_err_count"}, 64'(err_count), e_err);
    chk({tag, "_sum_ed"}, 64'(sum_ed), e_sed);
    chk({tag, "_max_ed"}, 64'(max_ed), e_max);
    chk({tag, "_sum_red"}, 64'(sum_red), e_red);
    chk({tag, "_nz_count"}, 64'(nz_count), e_nz);
  endtask

  task automatic do_start(input logic [31:0] n);
    start       = 1'b1;
    num_samples = n;
    @(posedge clk); #1;
    start       = 1'b0;
  endtask

  // Present a sample and hold it until accepted (bounded wait).
  task automatic send(input logic [15:0] a, input logic [15:0] e);
    int n;
    approx_s = a;
    exact_s  = e;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_done", 64'(done), 64'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    start       = 1'b0;
    num_samples = '0;
    in_valid    = 1'b0;
    approx_s    = '0;
    exact_s     = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values.
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk_results("rst", 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", 64'(busy), 64'd0);

    // Three samples, two needing division: 2 * floor(2560/100) = 50.
    do_start(32'd3);
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_in_ready", 64'(in_ready), 64'd1);
    send(16'd100, 16'd100);
    send(16'd110, 16'd100);
    send(16'd90, 16'd100);
    wait_done();
    chk("t1_busy", 64'(busy), 64'd0);
    chk_results("t1", 64'd2, 64'd20, 64'd10, 64'd50, 64'd1 + 64'd2);

    // Restart from DONE: zero exact sum and zero ED, no division ever.
    do_start(32'd2);
    chk("t2_done_cleared", 64'(done), 64'd0);
    send(16'd5, 16'd0);
    chk("t2_ready_after_first", 64'(in_ready), 64'd1);
    send(16'd7, 16'd7);
    chk("t2_done_immediate", 64'(done), 64'd1);
    chk_results("t2", 64'd1, 64'd5, 64'd5, 64'd0, 64'd1);

    // Backpressure: sample held from IDLE through DIV; counted once, in_ready low 24 cycles.
    pulse_reset();
    approx_s = 16'hFFFF;
    exact_s  = 16'h0001;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t3_idle_no_count", 64'(err_count), 64'd0);
    do_start(32'd1);
    @(posedge clk); #1;
    low_cnt = 0;
    while (busy && !in_ready && low_cnt < 100) begin
      low_cnt++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("t3_div_cycles", 64'(low_cnt), 64'd24);
    chk("t3_done", 64'(done), 64'd1);
    chk_results("t3", 64'd1, 64'hFFFE, 64'hFFFE, 64'hFFFE00, 64'd1);

    // Zero samples: DONE on the cycle after start.
    do_start(32'd0);
    chk("t4_done_next", 64'(done), 64'd1);
    chk_results("t4", 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);

    // start during RUN is ignored.
    do_start(32'd2);
    send(16'd8, 16'd0);
    do_start(32'd5);
    chk("t4_still_busy", 64'(busy), 64'd1);
    chk("t4_err_kept", 64'(err_count), 64'd1);
    chk("t4_sum_ed_kept", 64'(sum_ed), 64'd8);
    send(16'd2, 16'd0);
    chk("t4_done_after_two", 64'(done), 64'd1);
    chk_results("t4b", 64'd2, 64'd10, 64'd8, 64'd0, 64'd0);

    // Reset 10 cycles into DIV aborts immediately.
    do_start(32'd1);
    send(16'd20, 16'd10);
    chk("t5_in_div", 64'(in_ready), 64'd0);
    chk("t5_sum_ed_pre", 64'(sum_ed), 64'd10);
    repeat (9) @(posedge clk);
    #1;
    chk("t5_still_div", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_in_ready", 64'(in_ready), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    chk_results("t5_rst", 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_idle", 64'(busy), 64'd0);

    // Fresh run after abort: floor(256/4) = 64.
    do_start(32'd1);
    send(16'd3, 16'd4);
    wait_done();
    chk_results("t6", 64'd1, 64'd1, 64'd1, 64'd64, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
